// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver, N data bits LSB first, optional even parity, M stop bits.
module uart_rx #(
   parameter int unsigned N         = 8,
   parameter int unsigned M         = 1,
   parameter int unsigned PARITY_EN = 0,
   parameter int unsigned BAUD_RATE = 9600,
   parameter int unsigned CLK_FREQ  = 50000000
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         rx,
   output logic [N-1:0] data_out,
   output logic         data_valid,
   output logic         parity_err,
   output logic         frame_err,
   output logic         busy
);

   localparam int unsigned DIV_RAW  = CLK_FREQ / (BAUD_RATE * 16);
   localparam int unsigned DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned BITS_MAX = (N > M) ? N : M;
   localparam int unsigned BIT_W    = $clog2(BITS_MAX + 1);
   localparam int unsigned TICK_W   = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t             state;
   logic               rx_s1;
   logic               rx_s2;
   logic               rx_d;
   logic [DIV_W-1:0]   div_cnt;
   logic [TICK_W-1:0]  tick_cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic [N-1:0]       shreg;
   logic               par_bit;
   logic               stop_bad;
   logic               tick_c;
   logic               start_edge_c;

   assign tick_c       = (div_cnt == DIV_W'(DIV - 1));
   assign start_edge_c = rx_d & ~rx_s2;

   // Two-flop synchronizer plus one delayed copy for falling-edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   // Oversample tick divider, re-phased to the detected start edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
      end else if ((state == IDLE) && start_edge_c) begin
         div_cnt <= '0;
      end else if (tick_c) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Frame FSM: mid-bit sampling, shift register, parity/stop evaluation, registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         stop_bad   <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start_edge_c) begin
                  state    <= START;
                  busy     <= 1'b1;
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  stop_bad <= 1'b0;
               end
            end
            START: begin
               if (tick_c) begin
                  if (tick_cnt == TICK_W'(7)) begin
                     tick_cnt <= '0;
                     if (!rx_s2) begin
                        state <= DATA;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
            end
            DATA: begin
               if (tick_c) begin
                  if (tick_cnt == TICK_W'(15)) begin
                     tick_cnt <= '0;
                     shreg    <= (shreg >> 1) | (N'(rx_s2) << (N - 1));
                     if (bit_cnt == BIT_W'(N - 1)) begin
                        bit_cnt <= '0;
                        state   <= (PARITY_EN != 0) ? PARITY : STOP;
                     end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
            end
            PARITY: begin
               if (tick_c) begin
                  if (tick_cnt == TICK_W'(15)) begin
                     tick_cnt <= '0;
                     par_bit  <= rx_s2;
                     state    <= STOP;
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
            end
            STOP: begin
               if (tick_c) begin
                  if (tick_cnt == TICK_W'(15)) begin
                     tick_cnt <= '0;
                     stop_bad <= stop_bad | ~rx_s2;
                     if (bit_cnt == BIT_W'(M - 1)) begin
                        bit_cnt    <= '0;
                        data_out   <= shreg;
                        data_valid <= 1'b1;
                        parity_err <= (PARITY_EN != 0) ? (par_bit ^ (^shreg)) : 1'b0;
                        frame_err  <= stop_bad | ~rx_s2;
                        busy       <= 1'b0;
                        state      <= IDLE;
                     end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: three receiver configurations (plain, even parity, two stop bits) against a frame-level model.
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 1600000;
   localparam int unsigned BAUD     = 100000;
   localparam int unsigned BIT_CLKS = 16;

   typedef struct {
      int         dut;
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] rx = 3'b111;
   logic [7:0] dout [3];
   logic       dv   [3];
   logic       pe   [3];
   logic       fe   [3];
   logic       bz   [3];

   exp_t       exp_q[$];
   logic [7:0] m_d  [3];
   logic       m_pe [3];
   logic       m_fe [3];
   int         vcount [3];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   uart_rx #(.N(8), .M(1), .PARITY_EN(0), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ)) u_plain (
      .clk(clk), .reset_n(reset_n), .rx(rx[0]), .data_out(dout[0]), .data_valid(dv[0]),
      .parity_err(pe[0]), .frame_err(fe[0]), .busy(bz[0]));

   uart_rx #(.N(8), .M(1), .PARITY_EN(1), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ)) u_par (
      .clk(clk), .reset_n(reset_n), .rx(rx[1]), .data_out(dout[1]), .data_valid(dv[1]),
      .parity_err(pe[1]), .frame_err(fe[1]), .busy(bz[1]));

   uart_rx #(.N(8), .M(2), .PARITY_EN(0), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ)) u_stop2 (
      .clk(clk), .reset_n(reset_n), .rx(rx[2]), .data_out(dout[2]), .data_valid(dv[2]),
      .parity_err(pe[2]), .frame_err(fe[2]), .busy(bz[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Per-cycle comparison of every receiver against the frame model
   task automatic compare_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (!reset_n) begin
               m_d[k]  = 8'h00;
               m_pe[k] = 1'b0;
               m_fe[k] = 1'b0;
            end else if (dv[k]) begin
               vcount[k]++;
               if (exp_q.size() == 0 || exp_q[0].dut != k) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid dut%0d actual data_out=%02h required no pulse", k, dout[k]);
               end else begin
                  e       = exp_q.pop_front();
                  m_d[k]  = e.d;
                  m_pe[k] = e.pe;
                  m_fe[k] = e.fe;
               end
            end
            chk($sformatf("data_out_dut%0d", k), 32'(dout[k]), 32'(m_d[k]));
            chk($sformatf("parity_err_dut%0d", k), 32'(pe[k]), 32'(m_pe[k]));
            chk($sformatf("frame_err_dut%0d", k), 32'(fe[k]), 32'(m_fe[k]));
         end
      end
   endtask

   task automatic drive_bit(input int k, input logic b);
      rx[k] = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic idle(input int k, input int n);
      rx[k] = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Serialize one frame for receiver k and record what it must report
   task automatic send_frame(input int k, input logic [7:0] d, input logic pbit, input logic [1:0] stops);
      exp_t e;
      int   nstop;
      bit   pen;
      nstop = (k == 2) ? 2 : 1;
      pen   = (k == 1);
      e.dut = k;
      e.d   = d;
      e.pe  = pen ? (pbit ^ (^d)) : 1'b0;
      e.fe  = 1'b0;
      for (int i = 0; i < nstop; i++) if (!stops[i]) e.fe = 1'b1;
      exp_q.push_back(e);
      drive_bit(k, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(k, d[i]);
      if (pen) drive_bit(k, pbit);
      for (int i = 0; i < nstop; i++) drive_bit(k, stops[i]);
      chk($sformatf("frame_reported_dut%0d", k), 32'(exp_q.size()), 32'd0);
      chk($sformatf("busy_after_frame_dut%0d", k), 32'(bz[k]), 32'd0);
   endtask

   task automatic random_frames(input int k, input int count);
      logic [7:0] d;
      logic       flip;
      logic [1:0] st;
      bit         bad_prev;
      int         gap;
      bad_prev = 1'b0;
      idle(k, 40);
      for (int f = 0; f < count; f++) begin
         d    = 8'($urandom);
         flip = ($urandom_range(0, 3) == 0);
         st   = 2'b11;
         if ($urandom_range(0, 3) == 0) st[$urandom_range(0, (k == 2) ? 1 : 0)] = 1'b0;
         gap  = bad_prev ? 24 : int'($urandom_range(0, 20));
         idle(k, gap);
         send_frame(k, d, (^d) ^ flip, st);
         bad_prev = (st != 2'b11);
      end
      idle(k, 40);
   endtask

   initial begin
      int base;
      for (int k = 0; k < 3; k++) vcount[k] = 0;
      fork
         compare_loop();
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_data_out_dut%0d", k), 32'(dout[k]), 32'd0);
         chk($sformatf("rst_valid_dut%0d", k), 32'(dv[k]), 32'd0);
         chk($sformatf("rst_busy_dut%0d", k), 32'(bz[k]), 32'd0);
      end
      #2 reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Plain frame 0xA5
      base = vcount[0];
      send_frame(0, 8'hA5, 1'b0, 2'b11);
      chk("a5_data", 32'(dout[0]), 32'hA5);
      chk("a5_parity", 32'(pe[0]), 32'd0);
      chk("a5_frame", 32'(fe[0]), 32'd0);
      chk("a5_pulses", 32'(vcount[0] - base), 32'd1);

      // Even parity: correct bit then wrong bit
      idle(1, 20);
      send_frame(1, 8'h07, 1'b1, 2'b11);
      chk("par_ok_err", 32'(pe[1]), 32'd0);
      idle(1, 5);
      send_frame(1, 8'h07, 1'b0, 2'b11);
      chk("par_bad_err", 32'(pe[1]), 32'd1);
      chk("par_bad_data", 32'(dout[1]), 32'h07);

      // Start glitch of 4 clocks
      base = vcount[0];
      idle(0, 20);
      rx[0] = 1'b0;
      repeat (4) @(negedge clk);
      rx[0] = 1'b1;
      chk("glitch_busy_set", 32'(bz[0]), 32'd1);
      repeat (12) @(negedge clk);
      chk("glitch_busy_clear", 32'(bz[0]), 32'd0);
      repeat (20) @(negedge clk);
      chk("glitch_no_pulse", 32'(vcount[0] - base), 32'd0);

      // Low stop bit, line then held low
      base = vcount[0];
      send_frame(0, 8'h3C, 1'b0, 2'b10);
      chk("ferr_flag", 32'(fe[0]), 32'd1);
      chk("ferr_data", 32'(dout[0]), 32'h3C);
      rx[0] = 1'b0;
      repeat (48) @(negedge clk);
      chk("ferr_no_retrigger", 32'(vcount[0] - base), 32'd1);
      chk("ferr_busy_low", 32'(bz[0]), 32'd0);
      idle(0, 32);

      // Reset during data bit 4 of 0xFF, then a clean 0x55
      base = vcount[0];
      drive_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
      rx[0] = 1'b1;
      repeat (8) @(negedge clk);
      chk("pre_rst_busy", 32'(bz[0]), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_data", 32'(dout[0]), 32'd0);
      chk("mid_rst_valid", 32'(dv[0]), 32'd0);
      chk("mid_rst_perr", 32'(pe[0]), 32'd0);
      chk("mid_rst_ferr", 32'(fe[0]), 32'd0);
      chk("mid_rst_busy", 32'(bz[0]), 32'd0);
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      repeat (BIT_CLKS * 4) @(negedge clk);
      chk("rst_discard", 32'(vcount[0] - base), 32'd0);
      chk("rst_idle_busy", 32'(bz[0]), 32'd0);
      send_frame(0, 8'h55, 1'b0, 2'b11);
      chk("post_rst_data", 32'(dout[0]), 32'h55);

      // Two stop bits, back-to-back frames
      base = vcount[2];
      idle(2, 20);
      send_frame(2, 8'h12, 1'b0, 2'b11);
      chk("b2b_first", 32'(dout[2]), 32'h12);
      send_frame(2, 8'h34, 1'b0, 2'b11);
      chk("b2b_second", 32'(dout[2]), 32'h34);
      chk("b2b_pulses", 32'(vcount[2] - base), 32'd2);

      // Randomized frames on every configuration
      for (int k = 0; k < 3; k++) random_frames(k, 15);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter N, default 8, SHALL set the number of data bits per frame.
REQ-002 Parameter M, default 1, SHALL set the number of stop bits per frame (1 or 2).
REQ-003 Parameter PARITY_EN, default 0, SHALL enable one even-parity bit after the data bits when set to 1.
REQ-004 Parameter BAUD_RATE, default 9600, SHALL set the line bit rate in bit/s.
REQ-005 Parameter CLK_FREQ, default 50000000, SHALL set the clk frequency in Hz.
REQ-006 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 rx  input  1  SHALL be the asynchronous serial line, idle high.
REQ-009 data_out  output  N  SHALL hold the last received data word, LSB first on the line.
REQ-010 data_valid  output  1  SHALL pulse high for exactly one clk when a frame completes.
REQ-011 parity_err  output  1  SHALL flag a parity mismatch, qualified by data_valid.
REQ-012 frame_err  output  1  SHALL flag a low stop bit, qualified by data_valid.
REQ-013 busy  output  1  SHALL be high from start-bit detection until the frame ends or is rejected.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value only.
REQ-015 An internal oversample tick SHALL fire once every DIV = max(1, CLK_FREQ/(BAUD_RATE*16)) clk cycles (integer division).
REQ-016 The tick counter SHALL restart from 0 on the clk where a start edge is detected, so sampling is phase-aligned to that edge.
REQ-017 States SHALL be IDLE, START, DATA, PARITY, STOP, encoded in 3 bits.
REQ-018 IDLE: a synchronized 1->0 transition SHALL move to START and set busy.
REQ-019 START: at tick 8 (mid-bit), rx low SHALL move to DATA; rx high SHALL be treated as a glitch, return to IDLE, clear busy, and produce no data_valid.
REQ-020 DATA: every 16 ticks, rx SHALL be sampled and shifted in LSB first; after the Nth sample, go to PARITY if PARITY_EN=1, otherwise go to STOP.
REQ-021 PARITY: 16 ticks after the last data sample, rx SHALL be sampled; parity_err = sampled bit XOR (^data).
REQ-022 STOP: M samples SHALL be taken, 16 ticks apart; frame_err SHALL be set if any stop sample is low.
REQ-023 On the clk after the final stop sample: data_out, parity_err, and frame_err SHALL update; data_valid SHALL pulse; state SHALL return to IDLE; busy SHALL clear.
REQ-024 parity_err SHALL be 0 whenever PARITY_EN=0.
REQ-025 data_out, parity_err, and frame_err SHALL hold their values until the next completed frame.
REQ-026 A frame with frame_err=1 SHALL still assert data_valid and update data_out.
REQ-027 Bit and tick counters SHALL be wide enough for max(N, M) and 16 respectively, and SHALL never wrap mid-state.
REQ-028 A new start edge SHALL be recognized no earlier than the first clk in IDLE; a line held low after a frame error SHALL not retrigger until rx has gone high.

Reset
REQ-029 While reset_n=0: state=IDLE, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, synchronizer flops=1, all counters=0.
REQ-030 Deassertion of reset_n mid-frame SHALL leave the block in IDLE, discarding the partial frame with no data_valid.

Verification (CLK_FREQ=1600000, BAUD_RATE=100000 -> DIV=1, 16 clk/bit)
REQ-031 N=8, PARITY_EN=0: send 0xA5 -> data_valid pulses once, data_out=0xA5, parity_err=0, frame_err=0, busy low afterwards.
REQ-032 PARITY_EN=1: send 0x07 with parity bit 1 -> parity_err=0; repeat with parity bit 0 -> parity_err=1, data_out=0x07.
REQ-033 rx low for 4 clk, then high -> no data_valid, busy returns to 0 by mid-bit, state=IDLE.
REQ-034 Send 0x3C with stop bit 0 -> data_valid pulses, frame_err=1, data_out=0x3C; no new frame until rx returns high.
REQ-035 Assert reset_n=0 during data bit 4 of 0xFF -> all outputs 0 immediately; after release, a clean 0x55 frame is received correctly.
REQ-036 M=2: back-to-back frames 0x12 and 0x34 with no idle gap -> two data_valid pulses, with data_out 0x12 then 0x34.
